// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and framing constants for the 8N1 UART blocks.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int DEFAULT_CLKS_PER_BIT = 10417;
   localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clocks within one bit and strobes bit_end at the terminal count.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic bit_end
);
   localparam int W = $clog2(CLKS_PER_BIT);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      bit_end = run && (cnt_q == W'(CLKS_PER_BIT - 1));
      cnt_d   = (clear || bit_end) ? '0 : run ? cnt_q + W'(1) : cnt_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: serializes one byte per start pulse as an 8N1 frame; all outputs registered.
module uart_tx_8n1
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           idx_q, idx_d;
   logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic                 accept, bit_end;
   assign accept = (state_q == IDLE) && start;
   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .run    (state_q != IDLE),
      .bit_end(bit_end)
   );
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE:  if (start) begin
                   state_d = START;
                   shift_d = data;
                   idx_d   = '0;
                end
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end) begin
                   shift_d = shift_q >> 1;
                   idx_d   = idx_q + 3'd1;
                   if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
                end
         STOP:  if (bit_end) state_d = IDLE;
      endcase
      // outputs are precomputed from the next state so tx/busy/done come straight off flops
      tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
      busy_d = state_d != IDLE;
      done_d = (state_q == STOP) && bit_end;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: directed frame vectors plus hand-written corner sequences for uart_tx_8n1.
module tb_uart_tx_8n1;
   localparam int C = 4;
   logic       clk = 1'b0;
   logic       reset;
   logic       start, start2;
   logic [7:0] data, data2;
   logic       tx, busy, done, tx2, busy2, done2;
   int         total = 0;
   int         passed = 0;
   typedef struct {
      logic [7:0] d;
      logic [9:0] f;
   } vec_t;
   vec_t vecs[6];
   always #5 clk = ~clk;
   uart_tx_8n1 #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .reset(reset), .start(start), .data(data),
      .tx(tx), .busy(busy), .done(done)
   );
   uart_tx_8n1 dut_def (
      .clk(clk), .reset(reset), .start(start2), .data(data2),
      .tx(tx2), .busy(busy2), .done(done2)
   );
   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         check("idle_tx", tx, 1'b1);
         check("idle_busy", busy, 1'b0);
         check("idle_done", done, 1'b0);
      end
   endtask
   task automatic kick(input logic [7:0] d);
      @(negedge clk);
      start = 1'b1;
      data  = d;
   endtask
   // f[i] is the i-th bit on the line: start, d0..d7, stop
   task automatic run_frame(input logic [9:0] f, input int inj_k, input logic chain, input logic [7:0] cd);
      for (int k = 1; k <= 10 * C; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("frame_tx", tx, f[(k - 1) / C]);
         check("frame_busy", busy, 1'b1);
         check("frame_done", done, 1'b0);
         if (k == inj_k) begin
            start = 1'b1;
            data  = 8'h3C;
         end
      end
      @(negedge clk);
      start = 1'b0;
      check("end_done", done, 1'b1);
      check("end_busy", busy, 1'b0);
      check("end_tx", tx, 1'b1);
      if (chain) begin
         start = 1'b1;
         data  = cd;
      end
   endtask
   initial begin
      int lows;
      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'hFF, 10'b1111111110};
      vecs[2] = '{8'h00, 10'b1000000000};
      vecs[3] = '{8'h5A, 10'b1010110100};
      vecs[4] = '{8'h01, 10'b1000000010};
      vecs[5] = '{8'h80, 10'b1100000000};
      reset = 1'b1; start = 1'b0; data = 8'h00; start2 = 1'b0; data2 = 8'h00;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(1000);
      for (int i = 0; i < 6; i++) begin
         kick(vecs[i].d);
         run_frame(vecs[i].f, 0, 1'b0, 8'h00);
         idle(3);
      end
      kick(8'hFF);
      run_frame(10'b1111111110, 15, 1'b0, 8'h00);
      idle(50);
      kick(8'hA5);
      run_frame(10'b1101001010, 0, 1'b1, 8'h00);
      run_frame(10'b1000000000, 0, 1'b0, 8'h00);
      idle(3);
      kick(8'h00);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_rst_tx", tx, 1'b0);
      reset = 1'b1;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_done", done, 1'b0);
      repeat (2) @(negedge clk);
      check("hold_rst_done", done, 1'b0);
      reset = 1'b0;
      idle(5 * C);
      kick(8'h5A);
      run_frame(10'b1010110100, 0, 1'b0, 8'h00);
      idle(3);
      @(negedge clk);
      start2 = 1'b1;
      data2  = 8'h55;
      @(negedge clk);
      start2 = 1'b0;
      check("def_busy", busy2, 1'b1);
      check("def_done", done2, 1'b0);
      lows = 0;
      while (tx2 === 1'b0 && lows < 20000) begin
         lows++;
         @(negedge clk);
      end
      total++;
      if (lows == 10417) passed++;
      else $display("FAIL def_start_bit: got %0d cycles low expected 10417", lows);
      check("def_d0", tx2, 1'b1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/uart_tx_8n1.md
# uart_tx_8n1

Serializes one byte per request onto the Basys3 USB-UART TX line as 8N1 frames: one start bit, eight data bits LSB first, one stop bit, no parity. It sits downstream of the button debouncer; the debouncer's single-cycle press pulse drives `start` and the switch bank drives `data`. The block owns bit timing, frame sequencing and the idle line level.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per bit, which gives 9600 baud at 100 MHz. Legal range is ≥ 2.
- `clk` input, 1 bit: system clock, 100 MHz, all logic on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: one-cycle transmit request. Sampled only when idle.
- `data` input, 8 bits: byte to send. Sampled in the cycle `start` is accepted.
- `tx` output, 1 bit: serial line, registered. Idles high.
- `busy` output, 1 bit: high from the cycle after acceptance until the stop bit completes.
- `done` output, 1 bit: one-cycle pulse marking frame completion.

## Operation
- States are IDLE, START, DATA and STOP.
- **IDLE**
  - Outputs: `tx`=1, `busy`=0.
  - On `start`=1: latch `data` into the shift register, clear the bit counter and bit index, go to START.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx` = shift-register bit 0.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the 3-bit index.
  - After index 7 completes, go to STOP.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and pulse `done`.
- `start` outside IDLE is ignored. There is no queueing, and a changing `data` mid-frame has no effect.
- `done` is high only in the first IDLE cycle after STOP. `start` in that same cycle is accepted, so back-to-back frames are allowed.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. It counts 0 … `CLKS_PER_BIT`-1 and the bit ends at the terminal count.
- Reset, including mid-frame: state IDLE, `tx`=1, `busy`=0, `done`=0, counters and shift register 0. The partial frame is abandoned. The receiver sees a framing error, which is acceptable.

## Timing
- Acceptance at cycle N, i.e. the edge where `start`=1 in IDLE.
- From cycle N+1:
  - `tx`=0 and `busy`=1.
  - Start bit occupies cycles N+1 … N+`CLKS_PER_BIT`.
- Data bit k occupies cycles N+1+(k+1)·`CLKS_PER_BIT` … N+(k+2)·`CLKS_PER_BIT`.
- Stop bit ends at N+10·`CLKS_PER_BIT`.
- Cycle N+10·`CLKS_PER_BIT`+1: `done`=1, `busy`=0, `tx`=1.
- Total frame length on the line is exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames leave 1 idle cycle between stop bit and next start bit.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`.
  - Localparam `DEFAULT_CLKS_PER_BIT = 10417`.
  - Localparam `DATA_BITS = 8`.
  - The future `uart_rx_8n1` reuses this package.
- Sub-module `uart_bit_timer`:
  - Parameterized by `CLKS_PER_BIT`.
  - Inputs `clear` and `run`; output `bit_end`, a one-cycle terminal-count strobe.
  - Shared with the receiver.

## Test plan
- **Single byte.** `CLKS_PER_BIT`=4, pulse `start` with `data`=8'hA5.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `done` high exactly at cycle 41 after acceptance; `busy` high cycles 1–40.
- **Busy rejection.** Pulse `start` with 8'h3C mid-frame while sending 8'hFF.
  - Frame still carries 8'hFF, and no second frame follows.
- **Back-to-back.** Assert `start` with 8'h00 in the `done` cycle of a prior frame.
  - Next start bit begins the following cycle, and the second frame is all zeros plus the stop bit.
- **Reset mid-frame.** Assert `reset` during data bit 3.
  - `tx`=1 and `busy`=0 asynchronously, with no `done` pulse.
  - A fresh `start` with 8'h5A then sends a clean frame.
- **Idle hold.** No `start` for 1000 cycles after reset: `tx`=1, `busy`=0 and `done`=0 throughout.
- **Default baud.** With `CLKS_PER_BIT`=10417, the start bit measures exactly 10417 cycles low.
